// File: rtl/ram_delay_line_checker.sv
// Pattern source and delayed-stream sink for the RAM delay line: drives an
// incrementing count, acquires the loop latency, then counts mismatches while locked.
module ram_delay_line_checker #(
  parameter int DSIZE          = 10,
  parameter int MAX_LAT        = 64,
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int ECW            = 16,
  localparam int LW            = $clog2(MAX_LAT + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Clr,
  input  logic [DSIZE-1:0] Ret_in,
  output logic [DSIZE-1:0] Pat_out,
  output logic             Lock,
  output logic [LW-1:0]    Latency,
  output logic [ECW-1:0]   Err_count,
  output logic             Fail,
  output logic [1:0]       State
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] FAILED = 2'd3;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);

  logic [1:0]       state, state_n;
  logic [DSIZE-1:0] pat;
  logic [DSIZE-1:0] cand, cand_n;
  logic [DSIZE-1:0] diff;
  logic [MW-1:0]    match_cnt, match_n;
  logic [MW-1:0]    run_cnt, run_n;
  logic [TW-1:0]    timeout, timeout_n;
  logic [LW-1:0]    latency, latency_n;
  logic [ECW-1:0]   err;
  logic             fail;
  logic             diff_valid, lat_hit, err_inc, fail_set;

  // Distance between what was sent and what came back, in pattern steps.
  assign diff       = pat - Ret_in;
  assign diff_valid = (diff <= DSIZE'(MAX_LAT));
  assign lat_hit    = (diff == DSIZE'(latency));

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    match_n   = match_cnt;
    run_n     = run_cnt;
    timeout_n = timeout;
    latency_n = latency;
    err_inc   = 1'b0;
    fail_set  = 1'b0;
    if (!Enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n   = SEARCH;
          cand_n    = '0;
          match_n   = '0;
          timeout_n = '0;
        end
        SEARCH: begin
          if (diff_valid && (diff == cand)) begin
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state_n   = LOCKED;
              latency_n = cand[LW-1:0];
              run_n     = '0;
            end else begin
              match_n = match_cnt + MW'(1);
            end
          end else begin
            cand_n  = diff;
            match_n = '0;
          end
          // A lock on the final search cycle wins over the timeout.
          if (state_n != LOCKED) begin
            if (timeout == TW'(SEARCH_TIMEOUT - 1)) begin
              state_n  = FAILED;
              fail_set = 1'b1;
            end else begin
              timeout_n = timeout + TW'(1);
            end
          end
        end
        LOCKED: begin
          if (!lat_hit) begin
            err_inc = 1'b1;
            if (run_cnt == MW'(LOCK_COUNT - 1)) begin
              state_n   = SEARCH;
              timeout_n = '0;
              match_n   = '0;
              run_n     = '0;
              fail_set  = 1'b1;
            end else begin
              run_n = run_cnt + MW'(1);
            end
          end else begin
            run_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pat       <= '0;
      state     <= IDLE;
      cand      <= '0;
      match_cnt <= '0;
      run_cnt   <= '0;
      timeout   <= '0;
      latency   <= '0;
      err       <= '0;
      fail      <= 1'b0;
    end else begin
      if (Enable) pat <= pat + DSIZE'(1);
      state     <= state_n;
      cand      <= cand_n;
      match_cnt <= match_n;
      run_cnt   <= run_n;
      timeout   <= timeout_n;
      latency   <= latency_n;
      if (Clr) begin
        err  <= '0;
        fail <= 1'b0;
      end else begin
        if (err_inc && (err != '1)) err <= err + ECW'(1);
        if (fail_set) fail <= 1'b1;
      end
    end
  end

  assign Pat_out   = pat;
  assign Lock      = (state == LOCKED);
  assign Latency   = latency;
  assign Err_count = err;
  assign Fail      = fail;
  assign State     = state;

endmodule

// File: tb/tb_ram_delay_line_checker.sv
// Bench for ram_delay_line_checker: a modelled tapped delay line closes the loop,
// expected lock/fail events are queued by the stimulus and matched by a monitor.
module tb_ram_delay_line_checker;

  localparam int DSIZE          = 10;
  localparam int MAX_LAT        = 64;
  localparam int LOCK_COUNT     = 16;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int ECW            = 16;
  localparam int LW             = $clog2(MAX_LAT + 1);
  localparam int HIST           = 80;

  logic             Clock = 1'b0;
  logic             Reset, Enable, Clr;
  logic [DSIZE-1:0] Ret_in, Pat_out;
  logic             Lock;
  logic [LW-1:0]    Latency;
  logic [ECW-1:0]   Err_count;
  logic             Fail;
  logic [1:0]       State;

  ram_delay_line_checker #(
    .DSIZE(DSIZE), .MAX_LAT(MAX_LAT), .LOCK_COUNT(LOCK_COUNT),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .ECW(ECW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Clr(Clr), .Ret_in(Ret_in),
    .Pat_out(Pat_out), .Lock(Lock), .Latency(Latency), .Err_count(Err_count),
    .Fail(Fail), .State(State)
  );

  always #5 Clock = ~Clock;

  // Environment: delay line with a selectable tap, glitch injector and stuck-at-zero.
  logic [DSIZE-1:0] hist [HIST];
  logic [6:0]       tap;
  logic             glitch, tie_zero;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < HIST; i++) hist[i] <= '0;
    end else begin
      hist[0] <= Pat_out;
      for (int i = 1; i < HIST; i++) hist[i] <= hist[i-1];
    end
  end

  always_comb begin
    Ret_in = (tap == 7'd0) ? Pat_out : hist[tap - 7'd1];
    Ret_in = Ret_in ^ {{(DSIZE-1){1'b0}}, glitch};
    if (tie_zero) Ret_in = '0;
  end

  // Reference pattern: number of enabled cycles since reset, modulo 2^DSIZE.
  logic [DSIZE-1:0] pat_m;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) pat_m <= '0;
    else if (Enable) pat_m <= pat_m + DSIZE'(1);
  end

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    bit is_fail;
    int lat;
    int err;
    bit fail;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int ev_count = 0;
  int unsigned ev_cyc = 0;
  int exp_err = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every rising Lock or entry into the failure state consumes one expectation.
  initial begin
    logic       prev_lock;
    logic [1:0] prev_state;
    exp_t       e;
    prev_lock  = 1'b0;
    prev_state = 2'd0;
    forever begin
      @(negedge Clock);
      check("pat_out", int'(Pat_out), int'(pat_m));
      if (!Reset && ((Lock && !prev_lock) || (State == 2'd3 && prev_state != 2'd3))) begin
        ev_count++;
        ev_cyc = cyc;
        check("event_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("event_kind", int'(State == 2'd3), int'(e.is_fail));
          if (!e.is_fail) begin
            check("lock_latency", int'(Latency), e.lat);
            check("lock_err_count", int'(Err_count), e.err);
            check("lock_fail_flag", int'(Fail), int'(e.fail));
          end else begin
            check("fail_flag", int'(Fail), 1);
            check("fail_lock", int'(Lock), 0);
          end
        end
      end
      prev_lock  = Lock;
      prev_state = State;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic wait_event(input string name, input int base, input int budget,
                            input int unsigned t0, output int took);
    int n;
    n = 0;
    while (ev_count == base && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_in_time"}, int'(ev_count != base), 1);
    took = int'(ev_cyc - t0);
  endtask

  task automatic expect_lock(input int lat, input int err, input bit fail);
    exp_q.push_back('{1'b0, lat, err, fail});
  endtask

  task automatic expect_fail();
    exp_q.push_back('{1'b1, 0, 0, 1'b1});
  endtask

  task automatic pulse_clr();
    Clr = 1'b1;
    tick(1);
    Clr = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    int base, took, k, n, lats[4];
    int unsigned t0;
    Reset = 1'b1; Enable = 1'b0; Clr = 1'b0;
    tap = 7'd4; glitch = 1'b0; tie_zero = 1'b0;
    tick(3);
    check("rst_pat", int'(Pat_out), 0);
    check("rst_lock", int'(Lock), 0);
    check("rst_latency", int'(Latency), 0);
    check("rst_err", int'(Err_count), 0);
    check("rst_fail", int'(Fail), 0);
    check("rst_state", int'(State), 0);
    Reset = 1'b0;
    tick(2);
    check("idle_hold", int'(State), 0);

    // Lock through a 4-stage pipe, then run across the pattern wrap.
    base = ev_count; t0 = cyc;
    expect_lock(4, 0, 1'b0);
    Enable = 1'b1;
    wait_event("t1_lock", base, 40, t0, took);
    check("t1_lock_time", int'(took <= 22), 1);
    tick(2000);
    check("t1_err_after_wrap", int'(Err_count), 0);
    check("t1_still_locked", int'(Lock), 1);

    // Lengthen the pipe: 16 mismatches drop lock, then re-acquire at 15.
    base = ev_count; t0 = cyc;
    expect_lock(15, 16, 1'b1);
    tap = 7'd15;
    wait_event("t2_relock", base, 60, t0, took);
    check("t2_state", int'(State), 2);
    pulse_clr();
    check("t2_clr_err", int'(Err_count), 0);
    check("t2_clr_fail", int'(Fail), 0);
    check("t2_clr_keeps_lock", int'(Lock), 1);

    // Isolated glitches, then the longest burst that must not drop lock.
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) begin
      glitch = 1'b1;
      tick(1);
      glitch = 1'b0;
      exp_err++;
      tick($urandom_range(1, 6));
    end
    check("t4_isolated_err", int'(Err_count), exp_err);
    check("t4_isolated_lock", int'(Lock), 1);
    check("t4_isolated_fail", int'(Fail), 0);
    glitch = 1'b1;
    tick(LOCK_COUNT - 1);
    glitch = 1'b0;
    exp_err += LOCK_COUNT - 1;
    tick(2);
    check("t4_burst_err", int'(Err_count), exp_err);
    check("t4_burst_lock", int'(Lock), 1);
    check("t4_burst_fail", int'(Fail), 0);
    glitch = 1'b1; Clr = 1'b1;
    tick(1);
    glitch = 1'b0; Clr = 1'b0; exp_err = 0;
    check("t4_clr_priority", int'(Err_count), 0);
    tick(1);
    check("t4_clr_after", int'(Err_count), 0);

    // Disable: back to idle with results held.
    Enable = 1'b0;
    tick(1);
    check("dis_state", int'(State), 0);
    check("dis_lock", int'(Lock), 0);
    check("dis_latency_held", int'(Latency), 15);
    check("dis_err_held", int'(Err_count), exp_err);

    // Stuck-at-zero return: search times out after exactly SEARCH_TIMEOUT cycles.
    tick(HIST);
    tie_zero = 1'b1;
    base = ev_count; t0 = cyc;
    expect_fail();
    Enable = 1'b1;
    wait_event("t3_fail", base, SEARCH_TIMEOUT + 80, t0, took);
    check("t3_fail_time", took, SEARCH_TIMEOUT + 1);
    tick(5);
    check("t3_state_stays", int'(State), 3);
    Enable = 1'b0;
    tick(1);
    check("t3_idle", int'(State), 0);
    check("t3_fail_sticky", int'(Fail), 1);
    pulse_clr();
    check("t3_clr_fail", int'(Fail), 0);
    tie_zero = 1'b0;

    // Delay beyond MAX_LAT never locks.
    tap = 7'd70;
    tick(HIST);
    base = ev_count; t0 = cyc;
    expect_fail();
    Enable = 1'b1;
    wait_event("t5_fail", base, SEARCH_TIMEOUT + 80, t0, took);
    check("t5_fail_time", took, SEARCH_TIMEOUT + 1);
    Enable = 1'b0;
    tick(1);
    pulse_clr();

    // Boundary and random latencies, each acquired from a flushed line.
    lats[0] = 0;
    lats[1] = MAX_LAT;
    lats[2] = int'($urandom_range(1, MAX_LAT - 1));
    lats[3] = int'($urandom_range(1, MAX_LAT - 1));
    for (int i = 0; i < 4; i++) begin
      n = lats[i];
      Enable = 1'b0;
      tap = 7'(n);
      tick(HIST);
      base = ev_count; t0 = cyc;
      expect_lock(n, exp_err, 1'b0);
      Enable = 1'b1;
      wait_event("t6_lock", base, n + 60, t0, took);
      check("t6_lock_time", int'(took <= n + 22), 1);
    end

    // Reset while locked; re-acquire the same latency from a restarted pattern.
    tick(20);
    Reset = 1'b1;
    #1;
    check("t7_rst_pat", int'(Pat_out), 0);
    check("t7_rst_lock", int'(Lock), 0);
    check("t7_rst_latency", int'(Latency), 0);
    check("t7_rst_err", int'(Err_count), 0);
    check("t7_rst_fail", int'(Fail), 0);
    check("t7_rst_state", int'(State), 0);
    #99;
    base = ev_count; t0 = cyc;
    expect_lock(n, 0, 1'b0);
    Reset = 1'b0;
    wait_event("t7_relock", base, n + 60, t0, took);
    check("t7_relock_time", int'(took <= n + 22), 1);

    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_delay_line_checker.md
Name: ram_delay_line_checker

Overview:
Self-checking source/sink pair for the RAM-based delay line (shift register) path on the Nano4K board. It drives an incrementing pattern into the delay line and consumes the delayed stream returned by it. It then acquires the delay, reports the measured latency, and counts mismatches. On-board, it replaces the simulation-only stimulus so delay-line integrity is visible on LEDs/HDMI overlay.

Parameters:
DSIZE, 10, pattern/data width in bits
MAX_LAT, 64, largest delay accepted as valid during acquisition
LOCK_COUNT, 16, consecutive consistent samples required to lock / consecutive mismatches to drop lock
SEARCH_TIMEOUT, 1024, cycles allowed in SEARCH before declaring failure
ECW, 16, error counter width

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Enable  in  1  run; low freezes pattern and returns FSM to IDLE
Clr  in  1  synchronous clear of Err_count and Fail
Ret_in  in  DSIZE  delayed data returned from delay line
Pat_out  out  DSIZE  pattern driven into delay line input
Lock  out  1  high while in LOCKED
Latency  out  clog2(MAX_LAT+1)  measured delay in cycles (valid when Lock)
Err_count  out  ECW  saturating mismatch count while locked
Fail  out  1  sticky failure flag
State  out  2  FSM state for debug: 0 IDLE, 1 SEARCH, 2 LOCKED, 3 FAIL

Behaviour:
- Reset (async): Pat_out=0, Lock=0, Latency=0, Err_count=0, Fail=0, State=IDLE, internal match/mismatch/timeout counters=0.
- Pattern: Pat_out registered; when Enable=1, Pat_out <= Pat_out+1 every cycle, wrapping 2^DSIZE-1 -> 0. Enable=0 holds Pat_out.
- Difference: D = (Pat_out - Ret_in) mod 2^DSIZE, computed combinationally from the current register value and input. Valid candidate iff D <= MAX_LAT.
- IDLE: Enable=1 -> SEARCH, with cand=0, match_cnt=0, timeout=0.
- SEARCH, each cycle:
  - If D valid and D==cand: match_cnt++.
  - Otherwise: cand<=D, match_cnt<=0.
  - When match_cnt reaches LOCK_COUNT-1 with another match: -> LOCKED, Latency<=cand, mismatch run=0.
  - timeout increments each cycle. Reaching SEARCH_TIMEOUT without locking -> FAIL, Fail<=1.
- LOCKED, each cycle:
  - If D != Latency: Err_count++ (saturates at 2^ECW-1) and run++.
  - Else: run<=0.
  - run reaching LOCK_COUNT -> SEARCH, timeout=0, match_cnt=0, Fail<=1. Lock drops the cycle after the transition.
- FAIL: Lock=0. Stays until Enable=0 (-> IDLE) or Reset. Fail remains set until Clr or Reset.
- Enable=0 in any state -> IDLE next cycle. Latency and Err_count are held; no comparisons occur.
- Clr=1: Err_count<=0, Fail<=0 this cycle. Clr has priority over a simultaneous increment or set. Clr does not change State.
- Lock = (State==LOCKED), registered with the state.
- Latency definition: a delay line with N register stages between Pat_out and Ret_in yields Latency=N. A direct wire gives 0.
- Reset asserted mid-run: all outputs return to reset values immediately. After release, re-acquisition starts from SEARCH when Enable=1.

Test Plan:
1. Ret_in = Pat_out through 4-stage register pipe, Enable=1 after reset -> Lock=1 within 4+16+2 cycles, Latency=4, Err_count stays 0 for 2000 cycles, including Pat_out wrap 1023->0.
2. Locked at Latency=4, then switch pipe to 15 stages -> 16 mismatches counted, Fail=1, re-lock with Latency=15, Err_count=16.
3. Ret_in tied to 0 -> no lock. After 1024 cycles State=FAIL, Fail=1, Lock=0. Enable low -> State=IDLE, Fail still 1. Clr -> Fail=0.
4. Locked at Latency=4, flip bit 0 of Ret_in for 3 isolated cycles -> Err_count=3, Lock stays 1, Fail=0. Clr asserted in the same cycle as a mismatch -> Err_count=0.
5. Pipe of 70 stages (> MAX_LAT) -> never locks, FAIL after 1024 cycles.
6. Reset pulsed 100 ns while locked -> all outputs 0 during Reset. After release, re-lock to the same latency with Pat_out restarting at 0.
